instr_mem_ctrl: RTL

- Parametrised successor to the combinational instruction ROM: word-addressed instruction store with a registered, handshaked fetch port and a program-load port.
- Sits between the PC register/fetch stage and decode.
- Adds three things the ROM lacks: run-time program loading, fault reporting for misaligned or out-of-range PCs, and back-pressure via a one-entry response register.

---
 rtl/instr_mem_ctrl_pkg.sv | 16 +
 rtl/instr_mem_array.sv | 23 ++
 rtl/instr_mem_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared encodings for the instruction memory controller.
// Mode values, fault bit positions and the fault/NOP word.
package instr_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_DRAIN = 2'd1,
      MODE_LOAD  = 2'd2
   } mode_e;

   localparam int FAULT_MISALIGN = 0;
   localparam int FAULT_RANGE    = 1;

   localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/instr_mem_array.sv
// Single-port instruction RAM: synchronous write, registered read.
// Contents start at zero and are not touched by reset.
module instr_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction store with handshaked fetch port and program-load port.
// Fetch latency is one cycle through a one-entry response register.
module instr_mem_ctrl
   import instr_mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 512,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic [IDX_W:0]    load_cnt,
   output logic              load_err,
   output logic [1:0]        mode,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_pc,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [1:0]        rsp_fault
);

   localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(DEPTH);

   mode_e             state, state_n;
   logic              in_load;
   logic              ld_mis, ld_rng, ld_ok, ld_bad;
   logic              accept;
   logic [1:0]        fault_d;
   logic [IDX_W-1:0]  ram_addr;
   logic [DATA_W-1:0] ram_rdata;

   assign in_load = (state == MODE_LOAD);
   assign ld_mis  = |load_addr[1:0];
   assign ld_rng  = |load_addr[ADDR_W-1:IDX_W+2];
   assign ld_ok   = in_load && load_we && !ld_mis && !ld_rng;
   assign ld_bad  = in_load && load_we && (ld_mis || ld_rng);

   assign req_ready = (state == MODE_RUN) && !load_en &&
                      (!rsp_valid || rsp_ready);
   assign accept    = req_valid && req_ready;

   always_comb begin
      fault_d                 = 2'b00;
      fault_d[FAULT_MISALIGN] = |req_pc[1:0];
      fault_d[FAULT_RANGE]    = |req_pc[ADDR_W-1:IDX_W+2];
   end

   // Reads only happen in RUN and writes only in LOAD, so one port suffices.
   assign ram_addr = in_load ? load_addr[IDX_W+1:2] : req_pc[IDX_W+1:2];

   instr_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (ld_ok),
      .re    (accept),
      .addr  (ram_addr),
      .wdata (load_data),
      .rdata (ram_rdata)
   );

   assign rsp_instr = (rsp_valid && rsp_fault == 2'b00) ?
                      ram_rdata : DATA_W'(NOP_WORD);
   assign mode      = state;

   always_comb begin
      state_n = state;
      unique case (state)
         MODE_RUN: begin
            if (load_en) state_n = rsp_valid ? MODE_DRAIN : MODE_LOAD;
         end
         MODE_DRAIN: begin
            if (!load_en)                    state_n = MODE_RUN;
            else if (!rsp_valid || rsp_ready) state_n = MODE_LOAD;
         end
         MODE_LOAD: begin
            if (!load_en) state_n = MODE_RUN;
         end
         default: state_n = MODE_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= MODE_RUN;
         rsp_valid <= 1'b0;
         rsp_fault <= 2'b00;
      end else begin
         state <= state_n;
         if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= fault_d;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_cnt <= '0;
         load_err <= 1'b0;
      end else if (state_n == MODE_LOAD && !in_load) begin
         load_cnt <= '0;
         load_err <= 1'b0;
      end else begin
         if (ld_ok && load_cnt != CNT_MAX) load_cnt <= load_cnt + 1'b1;
         if (ld_bad) load_err <= 1'b1;
      end
   end

endmodule
